// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB/I2C register target.
//   sccb_state_t     - protocol state encoding
//   DEV_ADDR_DEFAULT - 7-bit on-wire address the target answers to
//   BYTE_W / REG_ADDR_W / DEV_ADDR_W / BIT_CNT_W - datapath widths
//   reg_addr_inc()   - register pointer increment with 16-bit wrap
package sccb_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned REG_ADDR_W = 16;
   localparam int unsigned DEV_ADDR_W = 7;
   localparam int unsigned BIT_CNT_W  = 4;

   localparam logic [DEV_ADDR_W-1:0] DEV_ADDR_DEFAULT = 7'h78;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV,
      ST_DEV_ACK,
      ST_RA_H,
      ST_RA_H_ACK,
      ST_RA_L,
      ST_RA_L_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_IGNORE
   } sccb_state_t;

   // Pointer advance; natural overflow gives the FFFF -> 0000 wrap.
   function automatic logic [REG_ADDR_W-1:0] reg_addr_inc(input logic [REG_ADDR_W-1:0] a);
      return a + REG_ADDR_W'(1);
   endfunction

endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: multi-flop synchronizer plus edge detect for one bus line.
//   clk    - sampling clock
//   rst_n  - async active-low reset; all flops preset to 1 (idle bus level)
//   din    - asynchronous bus line
//   level  - synchronized line value
//   rise_c - one-cycle pulse on a synchronized 0->1 transition
//   fall_c - one-cycle pulse on a synchronized 1->0 transition
module sccb_sync_edge #(
   parameter int unsigned STAGES = 2   // minimum 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Shift chain; prev holds the last synchronized value for edge compare.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level  = sync_q[STAGES-1];
   assign rise_c = sync_q[STAGES-1] & ~prev_q;
   assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C responder with a parallel register port.
// Frame: {addr7, r/w} byte, 16-bit register address (write), then data
// bytes; reads return bytes starting at the current register pointer.
//   meg25    - 25 MHz system clock (oversamples scl/sda)
//   reset_n  - async active-low reset
//   scl      - bus clock from the initiator
//   sda      - open-drain bus data (driven low or released)
//   reg_addr - current register pointer
//   wr_data  - received data byte
//   wr_valid - one-cycle strobe: write wr_data at reg_addr
//   rd_req   - one-cycle strobe: supply rd_data for reg_addr
//   rd_data  - read data, sampled one meg25 cycle after rd_req
//   busy     - high from an address-matched START until STOP
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [DEV_ADDR_W-1:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
   parameter int unsigned           SYNC_STAGES = 2
) (
   input  logic                  meg25,
   input  logic                  reset_n,
   input  logic                  scl,
   inout  tri                    sda,
   output logic [REG_ADDR_W-1:0] reg_addr,
   output logic [BYTE_W-1:0]     wr_data,
   output logic                  wr_valid,
   output logic                  rd_req,
   input  logic [BYTE_W-1:0]     rd_data,
   output logic                  busy
);

   logic scl_lvl, scl_rise_c, scl_fall_c;
   logic sda_lvl, sda_rise_c, sda_fall_c;
   logic start_c, stop_c;
   logic [BYTE_W-1:0] rx_byte_c;

   sccb_state_t            state_q,    state_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
   logic [BYTE_W-1:0]      shift_q,    shift_d;
   logic                   rw_q,       rw_d;
   logic                   first_q,    first_d;
   logic [REG_ADDR_W-1:0]  reg_addr_q, reg_addr_d;
   logic [BYTE_W-1:0]      wr_data_q,  wr_data_d;
   logic                   wr_valid_q, wr_valid_d;
   logic                   rd_req_q,   rd_req_d;
   logic                   busy_q,     busy_d;
   logic                   sda_oe_q,   sda_oe_d;

   sccb_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk    (meg25),
      .rst_n  (reset_n),
      .din    (scl),
      .level  (scl_lvl),
      .rise_c (scl_rise_c),
      .fall_c (scl_fall_c)
   );

   sccb_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk    (meg25),
      .rst_n  (reset_n),
      .din    (sda),
      .level  (sda_lvl),
      .rise_c (sda_rise_c),
      .fall_c (sda_fall_c)
   );

   // Bus conditions: sda edges while scl is high.
   assign start_c   = sda_fall_c & scl_lvl;
   assign stop_c    = sda_rise_c & scl_lvl;
   assign rx_byte_c = {shift_q[BYTE_W-2:0], sda_lvl};

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      first_d    = first_q;
      reg_addr_d = reg_addr_q;
      wr_data_d  = wr_data_q;
      wr_valid_d = 1'b0;
      rd_req_d   = 1'b0;
      busy_d     = busy_q;
      sda_oe_d   = sda_oe_q;

      // Read data arrives exactly one cycle after the request strobe.
      if (rd_req_q) begin
         shift_d = rd_data;
      end

      if (start_c) begin
         state_d   = ST_DEV;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else if (stop_c) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         case (state_q)
            ST_DEV: begin
               if (scl_rise_c) begin
                  shift_d   = rx_byte_c;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == BIT_CNT_W'(7)) begin
                     rw_d = sda_lvl;
                     if (rx_byte_c[BYTE_W-1:1] != DEV_ADDR) begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                     end
                  end
               end else if (scl_fall_c && bit_cnt_q == BIT_CNT_W'(8)) begin
                  state_d   = ST_DEV_ACK;
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b1;
                  busy_d    = 1'b1;
                  rd_req_d  = rw_q;
               end
            end

            ST_DEV_ACK: begin
               if (scl_fall_c) begin
                  bit_cnt_d = '0;
                  if (rw_q) begin
                     // First read bit goes out on the same edge the ACK ends.
                     state_d  = ST_RDATA;
                     sda_oe_d = ~shift_q[BYTE_W-1];
                     shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                  end else begin
                     state_d  = ST_RA_H;
                     sda_oe_d = 1'b0;
                  end
               end
            end

            ST_RA_H, ST_RA_L, ST_WDATA: begin
               if (scl_rise_c) begin
                  shift_d   = rx_byte_c;
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == BIT_CNT_W'(7)) begin
                     if (state_q == ST_RA_H) begin
                        reg_addr_d[REG_ADDR_W-1:BYTE_W] = rx_byte_c;
                     end else if (state_q == ST_RA_L) begin
                        reg_addr_d[BYTE_W-1:0] = rx_byte_c;
                     end
                  end
               end else if (scl_fall_c && bit_cnt_q == BIT_CNT_W'(8)) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b1;
                  if (state_q == ST_RA_H) begin
                     state_d = ST_RA_H_ACK;
                  end else if (state_q == ST_RA_L) begin
                     state_d = ST_RA_L_ACK;
                  end else begin
                     // Data bytes after the first advance the pointer first.
                     state_d    = ST_WDATA_ACK;
                     wr_data_d  = shift_q;
                     wr_valid_d = 1'b1;
                     first_d    = 1'b0;
                     if (!first_q) begin
                        reg_addr_d = reg_addr_inc(reg_addr_q);
                     end
                  end
               end
            end

            ST_RA_H_ACK: begin
               if (scl_fall_c) begin
                  state_d  = ST_RA_L;
                  sda_oe_d = 1'b0;
               end
            end

            ST_RA_L_ACK: begin
               if (scl_fall_c) begin
                  state_d  = ST_WDATA;
                  sda_oe_d = 1'b0;
                  first_d  = 1'b1;
               end
            end

            ST_WDATA_ACK: begin
               if (scl_fall_c) begin
                  state_d  = ST_WDATA;
                  sda_oe_d = 1'b0;
               end
            end

            ST_RDATA: begin
               if (scl_rise_c) begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end else if (scl_fall_c) begin
                  if (bit_cnt_q == BIT_CNT_W'(8)) begin
                     state_d   = ST_RDATA_ACK;
                     bit_cnt_d = '0;
                     sda_oe_d  = 1'b0;
                  end else begin
                     sda_oe_d = ~shift_q[BYTE_W-1];
                     shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                  end
               end
            end

            // A fall here can only follow a master ACK; NACK leaves on the rise.
            ST_RDATA_ACK: begin
               if (scl_rise_c) begin
                  if (!sda_lvl) begin
                     reg_addr_d = reg_addr_inc(reg_addr_q);
                     rd_req_d   = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end else if (scl_fall_c) begin
                  state_d   = ST_RDATA;
                  bit_cnt_d = '0;
                  sda_oe_d  = ~shift_q[BYTE_W-1];
                  shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
               end
            end

            ST_IDLE, ST_IGNORE: begin
               sda_oe_d = 1'b0;
            end

            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge meg25 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         reg_addr_q <= '0;
         wr_data_q  <= '0;
         wr_valid_q <= 1'b0;
         rd_req_q   <= 1'b0;
         busy_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         first_q    <= first_d;
         reg_addr_q <= reg_addr_d;
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         rd_req_q   <= rd_req_d;
         busy_q     <= busy_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign reg_addr = reg_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_valid = wr_valid_q;
   assign rd_req   = rd_req_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target acting as a bus initiator.
module tb_sccb_target;

   localparam int unsigned Q = 6;   // meg25 cycles per quarter scl period

   logic        meg25 = 1'b0;
   logic        reset_n;
   logic        scl;
   logic        m_sda_oe;
   wire         sda;
   logic [15:0] reg_addr;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        rd_req;
   logic [7:0]  rd_data;
   logic        busy;

   assign sda = m_sda_oe ? 1'b0 : 1'bz;
   pullup (sda);

   always #20 meg25 = ~meg25;

   sccb_target #(.DEV_ADDR(7'h78), .SYNC_STAGES(2)) dut (
      .meg25    (meg25),
      .reset_n  (reset_n),
      .scl      (scl),
      .sda      (sda),
      .reg_addr (reg_addr),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .rd_req   (rd_req),
      .rd_data  (rd_data),
      .busy     (busy)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [23:0] wr_q[$];
   logic [7:0]  rd_src[$];
   int          rd_cnt = 0;
   logic        dut_low_seen = 1'b0;

   typedef struct {
      logic [6:0]  dev;
      logic [15:0] ra;
      logic [7:0]  data;
      logic [3:0]  exp_ack;
      logic        exp_busy;
      int          exp_wr;
      logic [23:0] exp_ev;
   } wvec_t;

   wvec_t vecs[5];

   // Event recorder and read-data responder; rd_data is valid for one cycle only.
   initial begin : monitor
      rd_data = 8'hEE;
      forever begin
         @(posedge meg25);
         #1;
         if (wr_valid === 1'b1) wr_q.push_back({reg_addr, wr_data});
         if (!m_sda_oe && sda === 1'b0) dut_low_seen = 1'b1;
         if (rd_req === 1'b1) begin
            rd_cnt++;
            rd_data = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
         end else begin
            rd_data = 8'hEE;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge meg25);
   endtask

   task automatic m_start();
      m_sda_oe = 1'b0; tick(Q);
      scl = 1'b1;      tick(Q);
      m_sda_oe = 1'b1; tick(Q);
      scl = 1'b0;      tick(Q);
   endtask

   task automatic m_stop();
      m_sda_oe = 1'b1; tick(Q);
      scl = 1'b1;      tick(Q);
      m_sda_oe = 1'b0; tick(Q);
   endtask

   task automatic m_bit(input logic b, output logic s);
      m_sda_oe = ~b; tick(Q);
      scl = 1'b1;    tick(Q);
      s = sda;       tick(Q);
      scl = 1'b0;    tick(Q);
   endtask

   task automatic m_wbyte(input logic [7:0] b, output logic ack);
      logic s;
      for (int k = 7; k >= 0; k--) m_bit(b[k], s);
      m_bit(1'b1, s);
      ack = (s === 1'b0);
   endtask

   task automatic m_rbyte(input logic mack, output logic [7:0] d);
      logic s;
      for (int k = 7; k >= 0; k--) begin
         m_bit(1'b1, s);
         d[k] = s;
      end
      m_bit(~mack, s);
   endtask

   initial begin : main
      logic        a3, a2, a1, a0, s;
      logic [7:0]  rb;
      logic [7:0]  dev_w;
      string       tag;

      vecs[0] = '{7'h78, 16'h3008, 8'h82, 4'hF, 1'b1, 1, 24'h3008_82};
      vecs[1] = '{7'h3C, 16'h3008, 8'h82, 4'h0, 1'b0, 0, 24'h0};
      vecs[2] = '{7'h78, 16'h0000, 8'hFF, 4'hF, 1'b1, 1, 24'h0000_FF};
      vecs[3] = '{7'h79, 16'h1234, 8'h55, 4'h0, 1'b0, 0, 24'h0};
      vecs[4] = '{7'h78, 16'h8001, 8'h00, 4'hF, 1'b1, 1, 24'h8001_00};

      reset_n  = 1'b0;
      scl      = 1'b1;
      m_sda_oe = 1'b0;
      tick(3);
      check("rst sda",      32'(sda),      32'h1);
      check("rst reg_addr", 32'(reg_addr), 32'h0);
      check("rst wr_data",  32'(wr_data),  32'h0);
      check("rst wr_valid", 32'(wr_valid), 32'h0);
      check("rst rd_req",   32'(rd_req),   32'h0);
      check("rst busy",     32'(busy),     32'h0);
      reset_n = 1'b1;
      tick(Q);

      // Single-byte write transactions from the table.
      for (int i = 0; i < 5; i++) begin
         tag = $sformatf("v%0d", i);
         wr_q.delete();
         dut_low_seen = 1'b0;
         m_start();
         m_wbyte({vecs[i].dev, 1'b0}, a3);
         m_wbyte(vecs[i].ra[15:8], a2);
         m_wbyte(vecs[i].ra[7:0], a1);
         m_wbyte(vecs[i].data, a0);
         check({tag, " acks"}, 32'({a3, a2, a1, a0}), 32'(vecs[i].exp_ack));
         check({tag, " busy"}, 32'(busy), 32'(vecs[i].exp_busy));
         m_stop();
         tick(Q);
         check({tag, " busy after stop"}, 32'(busy), 32'h0);
         check({tag, " wr count"}, 32'(wr_q.size()), 32'(vecs[i].exp_wr));
         if (vecs[i].exp_wr == 1 && wr_q.size() > 0)
            check({tag, " wr event"}, 32'(wr_q[0]), 32'(vecs[i].exp_ev));
         if (vecs[i].exp_wr == 0)
            check({tag, " sda never driven"}, 32'(dut_low_seen), 32'h0);
      end

      // Burst write across the pointer wrap.
      wr_q.delete();
      m_start();
      m_wbyte(8'hF0, a3); m_wbyte(8'hFF, a2); m_wbyte(8'hFF, a1);
      m_wbyte(8'h11, a0); m_wbyte(8'h22, s);
      m_stop();
      tick(Q);
      check("burst acks", 32'({a3, a2, a1, a0, s}), 32'h1F);
      check("burst wr count", 32'(wr_q.size()), 32'h2);
      if (wr_q.size() == 2) begin
         check("burst wr0", 32'(wr_q[0]), 32'hFFFF11);
         check("burst wr1", 32'(wr_q[1]), 32'h000022);
      end

      // Address-only write, then a two-byte read (ACK then NACK).
      wr_q.delete();
      m_start();
      m_wbyte(8'hF0, a3); m_wbyte(8'h30, a2); m_wbyte(8'h0A, a1);
      m_stop();
      tick(Q);
      check("ptr set acks", 32'({a3, a2, a1}), 32'h7);
      check("ptr set no wr", 32'(wr_q.size()), 32'h0);
      check("ptr set reg_addr", 32'(reg_addr), 32'h300A);
      rd_src.delete();
      rd_src.push_back(8'h56);
      rd_src.push_back(8'h40);
      rd_cnt = 0;
      m_start();
      m_wbyte(8'hF1, a3);
      check("read dev ack", 32'(a3), 32'h1);
      m_rbyte(1'b1, rb);
      check("read byte0", 32'(rb), 32'h56);
      m_rbyte(1'b0, rb);
      check("read byte1", 32'(rb), 32'h40);
      check("read busy", 32'(busy), 32'h1);
      m_stop();
      tick(Q);
      check("read rd_req count", 32'(rd_cnt), 32'h2);
      check("read reg_addr", 32'(reg_addr), 32'h300B);
      check("read busy after stop", 32'(busy), 32'h0);

      // STOP in the middle of a data byte, then a normal write.
      wr_q.delete();
      m_start();
      m_wbyte(8'hF0, a3); m_wbyte(8'h12, a2); m_wbyte(8'h34, a1);
      m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b0, s);
      m_stop();
      tick(Q);
      check("partial no wr", 32'(wr_q.size()), 32'h0);
      check("partial busy", 32'(busy), 32'h0);
      check("partial reg_addr", 32'(reg_addr), 32'h1234);
      m_start();
      m_wbyte(8'hF0, a3); m_wbyte(8'h43, a2); m_wbyte(8'h21, a1); m_wbyte(8'h9A, a0);
      m_stop();
      tick(Q);
      check("post-partial acks", 32'({a3, a2, a1, a0}), 32'hF);
      check("post-partial wr count", 32'(wr_q.size()), 32'h1);
      if (wr_q.size() == 1) check("post-partial wr", 32'(wr_q[0]), 32'h43219A);

      // Reset asserted while the target holds the address ACK.
      dev_w = 8'hF0;
      m_start();
      for (int k = 7; k >= 0; k--) m_bit(dev_w[k], s);
      m_sda_oe = 1'b0;
      tick(Q);
      check("ack held before reset", 32'(sda), 32'h0);
      check("busy in ack slot", 32'(busy), 32'h1);
      reset_n = 1'b0;
      #1;
      check("reset sda released", 32'(sda), 32'h1);
      check("reset reg_addr", 32'(reg_addr), 32'h0);
      check("reset wr_data", 32'(wr_data), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset wr_valid/rd_req", 32'({wr_valid, rd_req}), 32'h0);
      tick(2);
      scl = 1'b1;
      tick(Q);
      reset_n = 1'b1;
      tick(Q);
      wr_q.delete();
      m_start();
      m_wbyte(8'hF0, a3); m_wbyte(8'h55, a2); m_wbyte(8'h55, a1); m_wbyte(8'hAA, a0);
      m_stop();
      tick(Q);
      check("post-reset acks", 32'({a3, a2, a1, a0}), 32'hF);
      check("post-reset wr count", 32'(wr_q.size()), 32'h1);
      if (wr_q.size() == 1) check("post-reset wr", 32'(wr_q[0]), 32'h5555AA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
